// File: rtl/arb_4req_rr.sv
// Four-requester arbiter with registered one-hot grant, fixed-priority or
// round-robin selection, and a hold limit that forces release under contention.
module arb_4req_rr #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       mode,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id,
   output logic       valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
   localparam bit         HOLD_EN    = (MAX_HOLD != 0);

   state_t     state, state_nxt;
   logic [3:0] gnt_nxt;
   logic [1:0] gnt_id_nxt;
   logic       valid_nxt;
   logic [1:0] last, last_nxt;
   logic [7:0] hold_cnt, hold_cnt_nxt;

   logic [1:0] winner;
   logic       owner_req;
   logic       competing;
   logic       hold_expired;
   logic       release_now;

   // Highest set index wins; callers only use the result when r is non-zero.
   function automatic logic [1:0] pick_fixed(input logic [3:0] r);
      logic [1:0] win;
      win = 2'd0;
      if (r[3])      win = 2'd3;
      else if (r[2]) win = 2'd2;
      else if (r[1]) win = 2'd1;
      return win;
   endfunction

   // Scan upward from the slot after the previous owner, wrapping mod 4;
   // the previous owner itself is examined last.
   function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] prev);
      logic [1:0] idx;
      logic [1:0] win;
      logic       found;
      win   = prev;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = prev + 2'(i);
         if (!found && r[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

   assign winner       = mode ? pick_rr(req, last) : pick_fixed(req);
   assign owner_req    = req[gnt_id];
   assign competing    = |(req & ~gnt);
   assign hold_expired = HOLD_EN && (hold_cnt == HOLD_LIMIT) && competing;
   assign release_now  = done || !owner_req || hold_expired;

   // NOTE: every variable this block writes gets its hold value first, so no
   // path through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt    = state;
      gnt_nxt      = gnt;
      gnt_id_nxt   = gnt_id;
      valid_nxt    = valid;
      last_nxt     = last;
      hold_cnt_nxt = hold_cnt;

      unique case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               state_nxt    = GRANT;
               gnt_nxt      = 4'b0001 << winner;
               gnt_id_nxt   = winner;
               valid_nxt    = 1'b1;
               last_nxt     = winner;
               hold_cnt_nxt = 8'd1;
            end
         end
         GRANT: begin
            if (release_now) begin
               // gnt_id keeps its value; it is meaningless while valid is low.
               state_nxt = IDLE;
               gnt_nxt   = 4'b0000;
               valid_nxt = 1'b0;
            end else if (hold_cnt != 8'hFF) begin
               hold_cnt_nxt = hold_cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            valid_nxt = 1'b0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= 4'b0000;
         gnt_id   <= 2'd0;
         valid    <= 1'b0;
         last     <= 2'd3;
         hold_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         gnt_id   <= gnt_id_nxt;
         valid    <= valid_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_arb_4req_rr.sv
// Directed bench for arb_4req_rr (MAX_HOLD=4): reset, fixed priority,
// round-robin rotation, forced release, coincident releases, reset mid-grant.
module tb_arb_4req_rr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       mode;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       valid;

   int errors = 0;
   int checks = 0;

   arb_4req_rr #(.MAX_HOLD(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .mode   (mode),
      .done   (done),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check gnt and valid; gnt_id only matters while a grant is live.
   task automatic expect_gnt(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id);
      check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
      check({tag, ".valid"}, 32'(valid), 32'(exp_gnt != 4'b0000));
      if (exp_gnt != 4'b0000) check({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
   endtask

   initial begin
      logic [1:0] rr_seq [5];
      rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

      rst_n = 1'b0;
      req   = 4'b0000;
      mode  = 1'b0;
      done  = 1'b0;

      // Reset then idle
      step();
      step();
      expect_gnt("rst", 4'b0000, 2'd0);
      check("rst.id", 32'(gnt_id), 32'd0);
      rst_n = 1'b1;
      step();
      expect_gnt("idle_noreq", 4'b0000, 2'd0);
      req = 4'b0100;
      step();
      expect_gnt("first_grant", 4'b0100, 2'd2);
      req = 4'b0000;
      step();
      expect_gnt("owner_drop", 4'b0000, 2'd0);
      step();

      // Fixed priority: 3 wins repeatedly while it keeps requesting
      mode = 1'b0;
      req  = 4'b1011;
      step();
      expect_gnt("fix_g1", 4'b1000, 2'd3);
      done = 1'b1;
      step();
      done = 1'b0;
      expect_gnt("fix_gap1", 4'b0000, 2'd0);
      step();
      expect_gnt("fix_g2", 4'b1000, 2'd3);
      done = 1'b1;
      step();
      done = 1'b0;
      expect_gnt("fix_gap2", 4'b0000, 2'd0);
      step();
      expect_gnt("fix_g3", 4'b1000, 2'd3);
      req = 4'b0011;
      step();
      expect_gnt("fix_gap3", 4'b0000, 2'd0);
      step();
      expect_gnt("fix_g4", 4'b0010, 2'd1);
      req = 4'b0000;
      step();
      expect_gnt("fix_end", 4'b0000, 2'd0);

      // Round-robin from reset: grants 0,1,2,3,0, valid 1,1,1,0
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      mode  = 1'b1;
      req   = 4'b1111;
      step();
      for (int g = 0; g < 5; g++) begin
         expect_gnt($sformatf("rr%0d_c0", g), 4'b0001 << rr_seq[g], rr_seq[g]);
         step();
         expect_gnt($sformatf("rr%0d_c1", g), 4'b0001 << rr_seq[g], rr_seq[g]);
         step();
         expect_gnt($sformatf("rr%0d_c2", g), 4'b0001 << rr_seq[g], rr_seq[g]);
         done = 1'b1;
         step();
         done = 1'b0;
         expect_gnt($sformatf("rr%0d_gap", g), 4'b0000, 2'd0);
         if (g < 4) step();
      end
      req = 4'b0000;
      step();
      expect_gnt("rr_end", 4'b0000, 2'd0);

      // Forced release after 4 cycles with a competitor waiting (last=0)
      req = 4'b0001;
      step();
      expect_gnt("hold_c1", 4'b0001, 2'd0);
      req = 4'b0011;
      step();
      expect_gnt("hold_c2", 4'b0001, 2'd0);
      step();
      expect_gnt("hold_c3", 4'b0001, 2'd0);
      step();
      expect_gnt("hold_c4", 4'b0001, 2'd0);
      step();
      expect_gnt("hold_forced", 4'b0000, 2'd0);
      step();
      expect_gnt("hold_next", 4'b0010, 2'd1);
      req = 4'b0001;
      step();
      expect_gnt("hold_rel1", 4'b0000, 2'd0);
      step();
      expect_gnt("solo_grant", 4'b0001, 2'd0);
      for (int c = 0; c < 22; c++) begin
         step();
         expect_gnt($sformatf("solo_hold%0d", c), 4'b0001, 2'd0);
      end
      req = 4'b0000;
      step();
      expect_gnt("solo_rel", 4'b0000, 2'd0);

      // Coincident done, owner drop and hold limit: one release, one gap
      req = 4'b0011;
      step();
      expect_gnt("sim_g", 4'b0010, 2'd1);
      step();
      step();
      step();
      expect_gnt("sim_c4", 4'b0010, 2'd1);
      done = 1'b1;
      req  = 4'b0001;
      step();
      done = 1'b0;
      expect_gnt("sim_rel", 4'b0000, 2'd0);
      step();
      expect_gnt("sim_next", 4'b0001, 2'd0);

      // Mode toggle mid-grant leaves the owner alone, applies at next arbitration
      mode = 1'b0;
      req  = 4'b1001;
      step();
      expect_gnt("mode_hold", 4'b0001, 2'd0);
      done = 1'b1;
      step();
      done = 1'b0;
      expect_gnt("mode_gap", 4'b0000, 2'd0);
      step();
      expect_gnt("mode_fixed", 4'b1000, 2'd3);

      // Reset mid-grant drops the grant and restores last=3
      rst_n = 1'b0;
      step();
      expect_gnt("rst_mid", 4'b0000, 2'd0);
      check("rst_mid.id", 32'(gnt_id), 32'd0);
      rst_n = 1'b1;
      mode  = 1'b1;
      req   = 4'b1111;
      step();
      expect_gnt("rst_rr_first", 4'b0001, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
